// File: rtl/stage_memory_if.sv
// ---------------------------------------------------------------------------
// stage_memory_if
//
// Purpose:
//   Data-memory request/response bus between the memory pipeline stage
//   (master) and the data memory (slave). At most one request is outstanding
//   at a time: a request is accepted on req_valid & req_ready, and the
//   matching response, which carries load data or a store acknowledge,
//   arrives later on resp_valid.
//
// Signals:
//   req_valid   master -> slave  request valid
//   req_ready   slave  -> master memory accepts the request
//   we          master -> slave  1 = store, 0 = load
//   addr        master -> slave  16-byte-aligned byte address (ADDR_W)
//   wdata       master -> slave  store data (DATA_W)
//   resp_valid  slave  -> master response valid (load data / store ack)
//   rdata       slave  -> master load data (DATA_W)
// ---------------------------------------------------------------------------
interface stage_memory_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic              req_valid;
    logic              req_ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] rdata;

    // The pipeline stage issues requests and consumes responses.
    modport master (
        output req_valid,
        output we,
        output addr,
        output wdata,
        input  req_ready,
        input  resp_valid,
        input  rdata
    );

    // The data memory accepts requests and produces responses.
    modport slave (
        input  req_valid,
        input  we,
        input  addr,
        input  wdata,
        output req_ready,
        output resp_valid,
        output rdata
    );
endinterface

// File: rtl/stage_memory.sv
// ---------------------------------------------------------------------------
// stage_memory
//
// Purpose:
//   Memory pipeline stage between execute and writeback. Takes one EX/MEM
//   bundle per handshake. Non-memory ops go straight into the MEM/WB
//   registers with one cycle of latency. Loads and stores are copied into
//   hold registers, issued to the data memory over the dmem bus, and only
//   retired into MEM/WB once the memory responds. Upstream is stalled for
//   the whole access.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_valid           EX/MEM bundle valid
//   mem_stall           upstream must hold the bundle and not advance
//   mem_result_src      00 ALU, 01 load data, 10 pc+4, 11 immediate
//   mem_reg_write       op writes the register file
//   mem_rd              destination register
//   mem_mem_read        load
//   mem_mem_write       store (wins if mem_mem_read is also set)
//   mem_alu_result      ALU result; low ADDR_W bits form the address
//   mem_write_data      store data
//   mem_pc_plus_4       pc+4
//   mem_imm_ext         extended immediate
//   dmem                data-memory bus (master side)
//   wb_valid            MEM/WB bundle valid this cycle
//   wb_result_src       registered result select
//   wb_reg_write        register-file write enable, 0 in bubble cycles
//   wb_rd               registered destination register
//   wb_alu_result       registered ALU result
//   wb_read_result      load data, 0 for anything that is not a load
//   wb_pc_plus_4        registered pc+4
//   wb_imm_ext          registered immediate
// ---------------------------------------------------------------------------
module stage_memory #(
    parameter int DATA_W = 128,
    parameter int PC_W   = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              mem_valid,
    output logic              mem_stall,
    input  logic [1:0]        mem_result_src,
    input  logic              mem_reg_write,
    input  logic [RD_W-1:0]   mem_rd,
    input  logic              mem_mem_read,
    input  logic              mem_mem_write,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic [PC_W-1:0]   mem_pc_plus_4,
    input  logic [DATA_W-1:0] mem_imm_ext,

    stage_memory_if.master    dmem,

    output logic              wb_valid,
    output logic [1:0]        wb_result_src,
    output logic              wb_reg_write,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_read_result,
    output logic [PC_W-1:0]   wb_pc_plus_4,
    output logic [DATA_W-1:0] wb_imm_ext
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              mem_op;
    logic              req_valid;

    logic [1:0]        hold_result_src_q, hold_result_src_d;
    logic              hold_reg_write_q,  hold_reg_write_d;
    logic [RD_W-1:0]   hold_rd_q,         hold_rd_d;
    logic              hold_is_store_q,   hold_is_store_d;
    logic [DATA_W-1:0] hold_alu_result_q, hold_alu_result_d;
    logic [DATA_W-1:0] hold_write_data_q, hold_write_data_d;
    logic [PC_W-1:0]   hold_pc_plus_4_q,  hold_pc_plus_4_d;
    logic [DATA_W-1:0] hold_imm_ext_q,    hold_imm_ext_d;

    logic              wb_valid_q,        wb_valid_d;
    logic [1:0]        wb_result_src_q,   wb_result_src_d;
    logic              wb_reg_write_q,    wb_reg_write_d;
    logic [RD_W-1:0]   wb_rd_q,           wb_rd_d;
    logic [DATA_W-1:0] wb_alu_result_q,   wb_alu_result_d;
    logic [DATA_W-1:0] wb_read_result_q,  wb_read_result_d;
    logic [PC_W-1:0]   wb_pc_plus_4_q,    wb_pc_plus_4_d;
    logic [DATA_W-1:0] wb_imm_ext_q,      wb_imm_ext_d;

    assign mem_op = mem_mem_read | mem_mem_write;

    // The request fields come only from the hold registers, so address, we
    // and wdata cannot change while a request waits for req_ready, even if
    // upstream misbehaves. The low four address bits are dropped to align
    // every access to a 16-byte vector.
    assign dmem.req_valid = req_valid;
    assign dmem.we        = hold_is_store_q;
    assign dmem.addr      = {hold_alu_result_q[ADDR_W-1:4], 4'b0000};
    assign dmem.wdata     = hold_write_data_q;

    assign wb_valid       = wb_valid_q;
    assign wb_result_src  = wb_result_src_q;
    assign wb_reg_write   = wb_reg_write_q;
    assign wb_rd          = wb_rd_q;
    assign wb_alu_result  = wb_alu_result_q;
    assign wb_read_result = wb_read_result_q;
    assign wb_pc_plus_4   = wb_pc_plus_4_q;
    assign wb_imm_ext     = wb_imm_ext_q;

    // Next-state and output logic. wb_valid and wb_reg_write default to 0 so
    // that every cycle without a retiring op is a bubble that cannot write
    // the register file. The wb data fields default to their current values
    // so they hold through bubbles. A response in IDLE or REQ is never
    // looked at, which is what makes a stale response after a reset
    // harmless.
    always_comb begin
        state_d           = state_q;
        req_valid         = 1'b0;
        mem_stall         = 1'b0;

        hold_result_src_d = hold_result_src_q;
        hold_reg_write_d  = hold_reg_write_q;
        hold_rd_d         = hold_rd_q;
        hold_is_store_d   = hold_is_store_q;
        hold_alu_result_d = hold_alu_result_q;
        hold_write_data_d = hold_write_data_q;
        hold_pc_plus_4_d  = hold_pc_plus_4_q;
        hold_imm_ext_d    = hold_imm_ext_q;

        wb_valid_d        = 1'b0;
        wb_reg_write_d    = 1'b0;
        wb_result_src_d   = wb_result_src_q;
        wb_rd_d           = wb_rd_q;
        wb_alu_result_d   = wb_alu_result_q;
        wb_read_result_d  = wb_read_result_q;
        wb_pc_plus_4_d    = wb_pc_plus_4_q;
        wb_imm_ext_d      = wb_imm_ext_q;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    if (mem_op) begin
                        mem_stall         = 1'b1;
                        hold_result_src_d = mem_result_src;
                        hold_reg_write_d  = mem_reg_write;
                        hold_rd_d         = mem_rd;
                        hold_is_store_d   = mem_mem_write;
                        hold_alu_result_d = mem_alu_result;
                        hold_write_data_d = mem_write_data;
                        hold_pc_plus_4_d  = mem_pc_plus_4;
                        hold_imm_ext_d    = mem_imm_ext;
                        state_d           = REQ;
                    end else begin
                        wb_valid_d        = 1'b1;
                        wb_reg_write_d    = mem_reg_write;
                        wb_result_src_d   = mem_result_src;
                        wb_rd_d           = mem_rd;
                        wb_alu_result_d   = mem_alu_result;
                        wb_read_result_d  = '0;
                        wb_pc_plus_4_d    = mem_pc_plus_4;
                        wb_imm_ext_d      = mem_imm_ext;
                    end
                end
            end

            REQ: begin
                req_valid = 1'b1;
                mem_stall = 1'b1;
                if (dmem.req_ready) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                mem_stall = !dmem.resp_valid;
                if (dmem.resp_valid) begin
                    wb_valid_d        = 1'b1;
                    wb_reg_write_d    = hold_reg_write_q & !hold_is_store_q;
                    wb_result_src_d   = hold_result_src_q;
                    wb_rd_d           = hold_rd_q;
                    wb_alu_result_d   = hold_alu_result_q;
                    wb_read_result_d  = hold_is_store_q ? '0 : dmem.rdata;
                    wb_pc_plus_4_d    = hold_pc_plus_4_q;
                    wb_imm_ext_d      = hold_imm_ext_q;
                    state_d           = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, hold and MEM/WB registers. Reset clears everything, so an
    // access in flight is abandoned and the request bus returns to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            hold_result_src_q <= '0;
            hold_reg_write_q  <= 1'b0;
            hold_rd_q         <= '0;
            hold_is_store_q   <= 1'b0;
            hold_alu_result_q <= '0;
            hold_write_data_q <= '0;
            hold_pc_plus_4_q  <= '0;
            hold_imm_ext_q    <= '0;
            wb_valid_q        <= 1'b0;
            wb_result_src_q   <= '0;
            wb_reg_write_q    <= 1'b0;
            wb_rd_q           <= '0;
            wb_alu_result_q   <= '0;
            wb_read_result_q  <= '0;
            wb_pc_plus_4_q    <= '0;
            wb_imm_ext_q      <= '0;
        end else begin
            state_q           <= state_d;
            hold_result_src_q <= hold_result_src_d;
            hold_reg_write_q  <= hold_reg_write_d;
            hold_rd_q         <= hold_rd_d;
            hold_is_store_q   <= hold_is_store_d;
            hold_alu_result_q <= hold_alu_result_d;
            hold_write_data_q <= hold_write_data_d;
            hold_pc_plus_4_q  <= hold_pc_plus_4_d;
            hold_imm_ext_q    <= hold_imm_ext_d;
            wb_valid_q        <= wb_valid_d;
            wb_result_src_q   <= wb_result_src_d;
            wb_reg_write_q    <= wb_reg_write_d;
            wb_rd_q           <= wb_rd_d;
            wb_alu_result_q   <= wb_alu_result_d;
            wb_read_result_q  <= wb_read_result_d;
            wb_pc_plus_4_q    <= wb_pc_plus_4_d;
            wb_imm_ext_q      <= wb_imm_ext_d;
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// ---------------------------------------------------------------------------
// tb_stage_memory
//
// Directed bench for stage_memory. Inputs change 1 ns after each rising
// edge and outputs are compared 1 ns later, well away from the edge. The
// bench plays both the upstream EX/MEM stage and the data memory.
// ---------------------------------------------------------------------------
module tb_stage_memory;

    localparam int DATA_W = 128;
    localparam int PC_W   = 32;
    localparam int ADDR_W = 32;
    localparam int RD_W   = 5;

    localparam logic [127:0] LOAD_DATA  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
    localparam logic [127:0] LOAD_DATA2 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    localparam logic [127:0] STORE_DATA = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;

    logic              clk;
    logic              rst;
    logic              mem_valid;
    logic              mem_stall;
    logic [1:0]        mem_result_src;
    logic              mem_reg_write;
    logic [RD_W-1:0]   mem_rd;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_write_data;
    logic [PC_W-1:0]   mem_pc_plus_4;
    logic [DATA_W-1:0] mem_imm_ext;
    logic              wb_valid;
    logic [1:0]        wb_result_src;
    logic              wb_reg_write;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_alu_result;
    logic [DATA_W-1:0] wb_read_result;
    logic [PC_W-1:0]   wb_pc_plus_4;
    logic [DATA_W-1:0] wb_imm_ext;

    int compared   = 0;
    int mismatched = 0;

    stage_memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dmem_bus ();

    stage_memory #(
        .DATA_W(DATA_W),
        .PC_W  (PC_W),
        .ADDR_W(ADDR_W),
        .RD_W  (RD_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_valid     (mem_valid),
        .mem_stall     (mem_stall),
        .mem_result_src(mem_result_src),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .mem_alu_result(mem_alu_result),
        .mem_write_data(mem_write_data),
        .mem_pc_plus_4 (mem_pc_plus_4),
        .mem_imm_ext   (mem_imm_ext),
        .dmem          (dmem_bus),
        .wb_valid      (wb_valid),
        .wb_result_src (wb_result_src),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_alu_result (wb_alu_result),
        .wb_read_result(wb_read_result),
        .wb_pc_plus_4  (wb_pc_plus_4),
        .wb_imm_ext    (wb_imm_ext)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one EX/MEM bundle from the upstream stage.
    task automatic applyStimulus(
        input logic         valid,
        input logic [1:0]   result_src,
        input logic         reg_write,
        input logic [4:0]   rd,
        input logic         mem_read,
        input logic         mem_write,
        input logic [127:0] alu_result,
        input logic [127:0] write_data,
        input logic [31:0]  pc_plus_4,
        input logic [127:0] imm_ext
    );
        mem_valid      = valid;
        mem_result_src = result_src;
        mem_reg_write  = reg_write;
        mem_rd         = rd;
        mem_mem_read   = mem_read;
        mem_mem_write  = mem_write;
        mem_alu_result = alu_result;
        mem_write_data = write_data;
        mem_pc_plus_4  = pc_plus_4;
        mem_imm_ext    = imm_ext;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    // One comparison: counts it, and on a difference counts and reports it.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyIdle();
        dmem_bus.req_ready  = 1'b0;
        dmem_bus.resp_valid = 1'b0;
        dmem_bus.rdata      = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_wb_valid",   128'(wb_valid),           '0);
        checkOutput("rst_reg_write",  128'(wb_reg_write),       '0);
        checkOutput("rst_req_valid",  128'(dmem_bus.req_valid), '0);
        checkOutput("rst_stall",      128'(mem_stall),          '0);
        checkOutput("rst_addr",       128'(dmem_bus.addr),      '0);
        checkOutput("rst_read",       wb_read_result,           '0);
        checkOutput("rst_alu",        wb_alu_result,            '0);
        rst = 1'b0;

        $display("[TB] ALU op");
        applyStimulus(1'b1, 2'b00, 1'b1, 5'd7, 1'b0, 1'b0, 128'h1234, '0, 32'h40, 128'h77);
        #1;
        checkOutput("alu_stall",      128'(mem_stall),          '0);
        checkOutput("alu_req_valid",  128'(dmem_bus.req_valid), '0);
        tick();
        applyIdle();
        #1;
        checkOutput("alu_wb_valid",   128'(wb_valid),           128'd1);
        checkOutput("alu_wb_alu",     wb_alu_result,            128'h1234);
        checkOutput("alu_wb_rd",      128'(wb_rd),              128'd7);
        checkOutput("alu_wb_read",    wb_read_result,           '0);
        checkOutput("alu_reg_write",  128'(wb_reg_write),       128'd1);
        checkOutput("alu_src",        128'(wb_result_src),      '0);
        checkOutput("alu_pc4",        128'(wb_pc_plus_4),       128'h40);
        checkOutput("alu_stall2",     128'(mem_stall),          '0);
        tick();
        #1;
        checkOutput("bub_wb_valid",   128'(wb_valid),           '0);
        checkOutput("bub_reg_write",  128'(wb_reg_write),       '0);
        checkOutput("bub_alu_hold",   wb_alu_result,            128'h1234);

        $display("[TB] load at 0x4C, memory ready at once");
        tick();
        dmem_bus.req_ready = 1'b1;
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd3, 1'b1, 1'b0, 128'h4C, '0, 32'h20, 128'h9);
        #1;
        checkOutput("ld_c0_stall",    128'(mem_stall),          128'd1);
        checkOutput("ld_c0_req",      128'(dmem_bus.req_valid), '0);
        tick();
        #1;
        checkOutput("ld_c1_req",      128'(dmem_bus.req_valid), 128'd1);
        checkOutput("ld_c1_addr",     128'(dmem_bus.addr),      128'h40);
        checkOutput("ld_c1_we",       128'(dmem_bus.we),        '0);
        checkOutput("ld_c1_stall",    128'(mem_stall),          128'd1);
        tick();
        dmem_bus.resp_valid = 1'b1;
        dmem_bus.rdata      = LOAD_DATA;
        #1;
        checkOutput("ld_c2_stall",    128'(mem_stall),          '0);
        checkOutput("ld_c2_req",      128'(dmem_bus.req_valid), '0);
        tick();
        dmem_bus.resp_valid = 1'b0;
        dmem_bus.rdata      = '0;
        applyIdle();
        #1;
        checkOutput("ld_c3_valid",    128'(wb_valid),           128'd1);
        checkOutput("ld_c3_read",     wb_read_result,           LOAD_DATA);
        checkOutput("ld_c3_src",      128'(wb_result_src),      128'd1);
        checkOutput("ld_c3_rd",       128'(wb_rd),              128'd3);
        checkOutput("ld_c3_reg_wr",   128'(wb_reg_write),       128'd1);
        tick();
        #1;
        checkOutput("ld_c4_valid",    128'(wb_valid),           '0);

        $display("[TB] store with req_ready low for three cycles");
        tick();
        dmem_bus.req_ready = 1'b0;
        applyStimulus(1'b1, 2'b00, 1'b1, 5'd9, 1'b0, 1'b1, 128'h1238, STORE_DATA, 32'h50, '0);
        #1;
        checkOutput("st_c0_stall",    128'(mem_stall),          128'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checkOutput("st_nr_req",   128'(dmem_bus.req_valid), 128'd1);
            checkOutput("st_nr_addr",  128'(dmem_bus.addr),      128'h1230);
            checkOutput("st_nr_we",    128'(dmem_bus.we),        128'd1);
            checkOutput("st_nr_wdata", dmem_bus.wdata,           STORE_DATA);
            checkOutput("st_nr_valid", 128'(wb_valid),           '0);
            checkOutput("st_nr_stall", 128'(mem_stall),          128'd1);
        end
        tick();
        dmem_bus.req_ready = 1'b1;
        #1;
        checkOutput("st_acc_req",     128'(dmem_bus.req_valid), 128'd1);
        checkOutput("st_acc_addr",    128'(dmem_bus.addr),      128'h1230);
        tick();
        dmem_bus.req_ready = 1'b0;
        #1;
        checkOutput("st_w1_req",      128'(dmem_bus.req_valid), '0);
        checkOutput("st_w1_stall",    128'(mem_stall),          128'd1);
        tick();
        #1;
        checkOutput("st_w2_stall",    128'(mem_stall),          128'd1);
        checkOutput("st_w2_valid",    128'(wb_valid),           '0);
        tick();
        dmem_bus.resp_valid = 1'b1;
        dmem_bus.rdata      = LOAD_DATA;
        #1;
        checkOutput("st_resp_stall",  128'(mem_stall),          '0);
        tick();
        dmem_bus.resp_valid = 1'b0;
        dmem_bus.rdata      = '0;
        applyIdle();
        #1;
        checkOutput("st_wb_valid",    128'(wb_valid),           128'd1);
        checkOutput("st_reg_write",   128'(wb_reg_write),       '0);
        checkOutput("st_read",        wb_read_result,           '0);
        checkOutput("st_alu",         wb_alu_result,            128'h1238);
        checkOutput("st_rd",          128'(wb_rd),              128'd9);
        tick();
        #1;
        checkOutput("st_after_valid", 128'(wb_valid),           '0);

        $display("[TB] read and write both set");
        tick();
        dmem_bus.req_ready = 1'b1;
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd12, 1'b1, 1'b1, 128'h80, 128'h55, 32'h60, '0);
        #1;
        checkOutput("rw_stall",       128'(mem_stall),          128'd1);
        tick();
        #1;
        checkOutput("rw_req",         128'(dmem_bus.req_valid), 128'd1);
        checkOutput("rw_we",          128'(dmem_bus.we),        128'd1);
        checkOutput("rw_addr",        128'(dmem_bus.addr),      128'h80);
        tick();
        dmem_bus.resp_valid = 1'b1;
        dmem_bus.rdata      = LOAD_DATA;
        #1;
        checkOutput("rw_resp_stall",  128'(mem_stall),          '0);
        tick();
        dmem_bus.resp_valid = 1'b0;
        dmem_bus.rdata      = '0;
        applyIdle();
        #1;
        checkOutput("rw_wb_valid",    128'(wb_valid),           128'd1);
        checkOutput("rw_read",        wb_read_result,           '0);
        checkOutput("rw_reg_write",   128'(wb_reg_write),       '0);

        $display("[TB] back-to-back load, ALU, jal, li");
        tick();
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd1, 1'b1, 1'b0, 128'h100, '0, 32'h100, '0);
        #1;
        checkOutput("b2b_ld_stall",   128'(mem_stall),          128'd1);
        tick();
        #1;
        checkOutput("b2b_ld_req",     128'(dmem_bus.req_valid), 128'd1);
        tick();
        dmem_bus.resp_valid = 1'b1;
        dmem_bus.rdata      = LOAD_DATA2;
        #1;
        checkOutput("b2b_ld_rstall",  128'(mem_stall),          '0);
        tick();
        dmem_bus.resp_valid = 1'b0;
        dmem_bus.rdata      = '0;
        applyStimulus(1'b1, 2'b00, 1'b1, 5'd2, 1'b0, 1'b0, 128'h55, '0, 32'h108, '0);
        #1;
        checkOutput("b2b_1_valid",    128'(wb_valid),           128'd1);
        checkOutput("b2b_1_rd",       128'(wb_rd),              128'd1);
        checkOutput("b2b_1_read",     wb_read_result,           LOAD_DATA2);
        checkOutput("b2b_1_src",      128'(wb_result_src),      128'd1);
        checkOutput("b2b_1_stall",    128'(mem_stall),          '0);
        tick();
        applyStimulus(1'b1, 2'b10, 1'b1, 5'd3, 1'b0, 1'b0, 128'h999, '0, 32'h104, '0);
        #1;
        checkOutput("b2b_2_valid",    128'(wb_valid),           128'd1);
        checkOutput("b2b_2_rd",       128'(wb_rd),              128'd2);
        checkOutput("b2b_2_alu",      wb_alu_result,            128'h55);
        checkOutput("b2b_2_read",     wb_read_result,           '0);
        checkOutput("b2b_2_src",      128'(wb_result_src),      '0);
        tick();
        applyStimulus(1'b1, 2'b11, 1'b1, 5'd4, 1'b0, 1'b0, '0, '0, 32'h10C, 128'h5);
        #1;
        checkOutput("b2b_3_valid",    128'(wb_valid),           128'd1);
        checkOutput("b2b_3_rd",       128'(wb_rd),              128'd3);
        checkOutput("b2b_3_src",      128'(wb_result_src),      128'd2);
        checkOutput("b2b_3_pc4",      128'(wb_pc_plus_4),       128'h104);
        tick();
        applyIdle();
        #1;
        checkOutput("b2b_4_valid",    128'(wb_valid),           128'd1);
        checkOutput("b2b_4_rd",       128'(wb_rd),              128'd4);
        checkOutput("b2b_4_src",      128'(wb_result_src),      128'd3);
        checkOutput("b2b_4_imm",      wb_imm_ext,               128'h5);
        tick();
        #1;
        checkOutput("b2b_end_valid",  128'(wb_valid),           '0);

        $display("[TB] reset in WAIT, then a stale response");
        tick();
        dmem_bus.req_ready = 1'b1;
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd6, 1'b1, 1'b0, 128'h200, '0, 32'h200, '0);
        tick();
        tick();
        dmem_bus.req_ready = 1'b0;
        #1;
        checkOutput("rw8_wait_stall", 128'(mem_stall),          128'd1);
        rst = 1'b1;
        applyIdle();
        #1;
        checkOutput("rw8_rst_stall",  128'(mem_stall),          '0);
        checkOutput("rw8_rst_req",    128'(dmem_bus.req_valid), '0);
        checkOutput("rw8_rst_valid",  128'(wb_valid),           '0);
        checkOutput("rw8_rst_addr",   128'(dmem_bus.addr),      '0);
        checkOutput("rw8_rst_pc4",    128'(wb_pc_plus_4),       '0);
        checkOutput("rw8_rst_imm",    wb_imm_ext,               '0);
        tick();
        rst = 1'b0;
        dmem_bus.resp_valid = 1'b1;
        dmem_bus.rdata      = LOAD_DATA;
        #1;
        checkOutput("stale_stall",    128'(mem_stall),          '0);
        checkOutput("stale_req",      128'(dmem_bus.req_valid), '0);
        tick();
        dmem_bus.resp_valid = 1'b0;
        dmem_bus.rdata      = '0;
        #1;
        checkOutput("stale_valid",    128'(wb_valid),           '0);
        checkOutput("stale_read",     wb_read_result,           '0);
        checkOutput("stale_reg_wr",   128'(wb_reg_write),       '0);
        tick();
        #1;
        checkOutput("stale_valid2",   128'(wb_valid),           '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
